// File: rtl/alu_seq_if.sv
// alu_seq_if -- bundle of the request, ALU and write-back signals of the
// ALU sequencer.
//
// Signal groups:
//   request    : req_valid, req_ready, req_op, req_a, req_b, req_dst
//   ALU side   : alu_a, alu_b, alu_op, alu_en (driven), alu_res, alu_zero, alu_carry (returned)
//   write-back : wb_valid, wb_addr, wb_data
//   status     : flag_z, flag_c, busy
//
// Modports:
//   slave  : the sequencer (alu_seq_ctrl)
//   master : the environment (decode stage, ALU and register bank)
interface alu_seq_if #(
    parameter int ADDR_W = 5
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_op;
    logic [31:0]       req_a;
    logic [31:0]       req_b;
    logic [ADDR_W-1:0] req_dst;

    logic [31:0]       alu_a;
    logic [31:0]       alu_b;
    logic [3:0]        alu_op;
    logic              alu_en;
    logic [31:0]       alu_res;
    logic              alu_zero;
    logic              alu_carry;

    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [31:0]       wb_data;

    logic              flag_z;
    logic              flag_c;
    logic              busy;

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_dst,
        input  alu_res, alu_zero, alu_carry,
        output req_ready,
        output alu_a, alu_b, alu_op, alu_en,
        output wb_valid, wb_addr, wb_data,
        output flag_z, flag_c, busy
    );

    modport master (
        output req_valid, req_op, req_a, req_b, req_dst,
        output alu_res, alu_zero, alu_carry,
        input  req_ready,
        input  alu_a, alu_b, alu_op, alu_en,
        input  wb_valid, wb_addr, wb_data,
        input  flag_z, flag_c, busy
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl -- sequencer in front of a 32-bit, shift-by-one ALU.
//
// Accepts one operation request, drives the ALU operands/opcode/enable,
// captures the ALU result and flags, and issues a single-cycle register-bank
// write-back. Multi-bit shifts (SLA/SRA/SRL by req_b[SHAMT_W-1:0]) are
// executed as a chain of one-bit ALU passes, one per cycle.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_seq_if.slave -- request handshake, ALU drive/return,
//           write-back strobe/address/data, flags and busy
//
// Build option:
//   ALU_SEQ_FWD_EN : when defined, a new request is also accepted in the
//                    write-back cycle, so back-to-back non-shift ops retire
//                    every 2 cycles instead of every 3.
module alu_seq_ctrl #(
    parameter int ADDR_W  = 5,
    parameter int SHAMT_W = 5
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    localparam logic [3:0]         OP_ADD  = 4'd1;
    localparam logic [3:0]         OP_SLA  = 4'd7;
    localparam logic [3:0]         OP_SRA  = 4'd8;
    localparam logic [3:0]         OP_SRL  = 4'd9;
    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        SHIFT,
        WB
    } state_t;

    state_t state_q, state_d;

    // alu_a_q doubles as the shift accumulator: each SHIFT cycle feeds the
    // previous one-bit result back as the next operand.
    logic [31:0]        alu_a_q;
    logic [31:0]        alu_b_q;
    logic [3:0]         alu_op_q;
    logic [ADDR_W-1:0]  dst_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic [31:0]        res_q;
    logic               flag_z_q;
    logic               flag_c_q;

    logic               ready;
    logic               alu_en;
    logic               wb_valid;
    logic               busy;
    logic               accept;
    logic               req_shift;
    logic               last_alu;
    logic [SHAMT_W-1:0] req_shamt;

    assign req_shamt = bus.req_b[SHAMT_W-1:0];
    assign req_shift = (bus.req_op == OP_SLA) || (bus.req_op == OP_SRA) ||
                       (bus.req_op == OP_SRL);
    assign accept    = bus.req_valid && ready;

    // Final ALU pass of the current op: its result and flags are the ones
    // written back.
    assign last_alu  = (state_q == EXEC) ||
                       ((state_q == SHIFT) && (cnt_q <= CNT_ONE));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, WB: begin
                if (accept) begin
                    state_d = req_shift ? SHIFT : EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                state_d = WB;
            end
            SHIFT: begin
                if (cnt_q > CNT_ONE) begin
                    state_d = SHIFT;
                end else begin
                    state_d = WB;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        ready    = 1'b0;
        alu_en   = 1'b0;
        wb_valid = 1'b0;
        busy     = 1'b1;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                busy  = 1'b0;
            end
            EXEC, SHIFT: begin
                alu_en = 1'b1;
            end
            WB: begin
                wb_valid = 1'b1;
`ifdef ALU_SEQ_FWD_EN
                ready    = 1'b1;
`else
                ready    = 1'b0;
`endif
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Operand, counter, result and flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            dst_q    <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            if (accept) begin
                alu_a_q  <= bus.req_a;
                alu_op_q <= bus.req_op;
                dst_q    <= bus.req_dst;
                cnt_q    <= req_shamt;
                // A zero shift count still makes one ALU pass, with a
                // shift distance of 0 so the result is operand A.
                alu_b_q  <= req_shift ? {31'd0, (req_shamt != '0)} : bus.req_b;
            end else if (state_q == SHIFT) begin
                alu_a_q <= bus.alu_res;
                if (cnt_q > CNT_ONE) begin
                    cnt_q <= cnt_q - CNT_ONE;
                end
            end

            if (last_alu) begin
                res_q    <= bus.alu_res;
                flag_z_q <= bus.alu_zero;
                // The ALU may report a carry for other ops (borrow, shifted
                // out bit); only an ADD carry-out is architecturally visible.
                flag_c_q <= bus.alu_carry && (alu_op_q == OP_ADD);
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.alu_en    = alu_en;
    assign bus.wb_valid  = wb_valid;
    assign bus.wb_addr   = dst_q;
    assign bus.wb_data   = res_q;
    assign bus.flag_z    = flag_z_q;
    assign bus.flag_c    = flag_c_q;
    assign bus.busy      = busy;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
module tb_alu_seq_ctrl;
  localparam int ADDR_W = 5;
`ifdef ALU_SEQ_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int errors = 0;

  alu_seq_if #(.ADDR_W(ADDR_W)) bus();

  alu_seq_ctrl #(.ADDR_W(ADDR_W), .SHAMT_W(5)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // ---------------- ALU: one-bit shifter, returns {carry, result} ----------------
  function automatic logic [32:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [32:0] r;
    case (op)
      4'd1: r = {1'b0, a} + {1'b0, b};
      4'd2: r = {1'b0, a} + {1'b0, ~b} + 33'd1;
      4'd3: r = {1'b0, a & b};
      4'd4: r = {1'b0, a | b};
      4'd5: r = {1'b0, a ^ b};
      4'd6: r = {1'b0, ~a};
      4'd7: r = (b != 32'd0) ? {a[31], a[30:0], 1'b0} : {1'b0, a};
      4'd8: r = (b != 32'd0) ? {a[0], a[31], a[31:1]} : {1'b0, a};
      4'd9: r = (b != 32'd0) ? {a[0], 1'b0, a[31:1]} : {1'b0, a};
      default: r = '0;
    endcase
    return r;
  endfunction

  // A released bus is modelled as junk so a capture outside an enabled cycle shows up.
  logic [32:0] alu_out;
  assign alu_out       = alu_model(bus.alu_op, bus.alu_a, bus.alu_b);
  assign bus.alu_res   = bus.alu_en ? alu_out[31:0] : 32'hA5A5_5A5A;
  assign bus.alu_zero  = bus.alu_en ? (alu_out[31:0] == 32'd0) : 1'b1;
  assign bus.alu_carry = bus.alu_en ? alu_out[32] : 1'b1;

  // ---------------- reference model: whole-op results and timeline ----------------
  function automatic logic [31:0] exp_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [4:0] n;
    n = b[4:0];
    case (op)
      4'd1: return a + b;
      4'd2: return a - b;
      4'd3: return a & b;
      4'd4: return a | b;
      4'd5: return a ^ b;
      4'd6: return ~a;
      4'd7: return a << n;
      4'd8: return 32'($signed(a) >>> n);
      4'd9: return a >> n;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic exp_carry(input logic [3:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (op == 4'd1) && s[32];
  endfunction

  int          cyc = 0;
  int          t_acc = -10;
  int          t_wb = -10;
  bit          have_op = 1'b0;
  bit          m_shift = 1'b0;
  logic [3:0]  m_op = '0;
  logic [31:0] m_a = '0, m_b = '0, m_res = '0;
  logic [4:0]  m_dst = '0, m_n = '0;
  logic        m_cexp = 1'b0;
  logic        m_fz = 1'b0, m_fc = 1'b0;

  function automatic bit m_busy(input int c);
    return have_op && (c > t_acc) && (c <= t_wb);
  endfunction

  function automatic bit m_ready(input int c);
    return !m_busy(c) || (FWD && have_op && (c == t_wb));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have_op = 1'b0;
      m_fz    = 1'b0;
      m_fc    = 1'b0;
    end else begin
      if (bus.req_valid && m_ready(cyc)) begin
        m_op    = bus.req_op;
        m_a     = bus.req_a;
        m_b     = bus.req_b;
        m_dst   = bus.req_dst;
        m_n     = bus.req_b[4:0];
        m_shift = (bus.req_op >= 4'd7) && (bus.req_op <= 4'd9);
        m_res   = exp_result(m_op, m_a, m_b);
        m_cexp  = exp_carry(m_op, m_a, m_b);
        t_acc   = cyc;
        t_wb    = cyc + ((m_shift && (m_n > 5'd1)) ? (int'(m_n) + 1) : 2);
        have_op = 1'b1;
      end
      cyc = cyc + 1;
      if (have_op && (cyc == t_wb)) begin
        m_fz = (m_res == 32'd0);
        m_fc = m_cexp;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- per-cycle comparison against the model ----------------
  always @(negedge clk) begin : cmp
    bit          infl;
    bit          wbv;
    int          k;
    logic [31:0] ea;
    infl = m_busy(cyc);
    wbv  = have_op && (cyc == t_wb);
    chk("req_ready", 32'(bus.req_ready), 32'(m_ready(cyc)));
    chk("busy",      32'(bus.busy),      32'(infl));
    chk("alu_en",    32'(bus.alu_en),    32'(infl && !wbv));
    chk("wb_valid",  32'(bus.wb_valid),  32'(wbv));
    chk("flag_z",    32'(bus.flag_z),    32'(m_fz));
    chk("flag_c",    32'(bus.flag_c),    32'(m_fc));
    if (infl && !wbv) begin
      k  = cyc - t_acc;
      ea = m_shift ? exp_result(m_op, m_a, 32'(k - 1)) : m_a;
      chk("alu_op", 32'(bus.alu_op), 32'(m_op));
      chk("alu_a",  bus.alu_a, ea);
      chk("alu_b",  bus.alu_b, m_shift ? 32'(m_n != 5'd0) : m_b);
    end
    if (wbv) begin
      chk("wb_addr", 32'(bus.wb_addr), 32'(m_dst));
      chk("wb_data", bus.wb_data, m_res);
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] dst);
    bit took;
    took = 1'b0;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_dst   = dst;
    bus.req_valid = 1'b1;
    for (int w = 0; w < 64 && !took; w++) begin
      @(negedge clk);
      took = bus.req_ready;
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    checks++;
    if (!took) begin
      errors++;
      $display("FAIL send_accept: request op %0d never accepted within 64 cycles", op);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_dst   = '0;
    #1 rst_n = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_ready",  32'(bus.req_ready), 32'd1);
    chk("rst_busy",   32'(bus.busy),      32'd0);
    chk("rst_alu_en", 32'(bus.alu_en),    32'd0);
    chk("rst_wbv",    32'(bus.wb_valid),  32'd0);
    chk("rst_flags",  32'({bus.flag_z, bus.flag_c}), 32'd0);
    chk("rst_alu_a",  bus.alu_a, 32'd0);
    chk("rst_alu_b",  bus.alu_b, 32'd0);
    chk("rst_alu_op", 32'(bus.alu_op), 32'd0);
    chk("rst_wb",     bus.wb_data | 32'(bus.wb_addr), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // ADD 0xFFFFFFFF + 1 -> 0 with carry
    send(4'd1, 32'hFFFF_FFFF, 32'd1, 5'd3);
    @(negedge clk);
    chk("add_c1_en", 32'(bus.alu_en), 32'd1);
    chk("add_c1_a",  bus.alu_a, 32'hFFFF_FFFF);
    chk("add_c1_b",  bus.alu_b, 32'd1);
    @(negedge clk);
    chk("add_c2_wbv",  32'(bus.wb_valid), 32'd1);
    chk("add_c2_addr", 32'(bus.wb_addr), 32'd3);
    chk("add_c2_data", bus.wb_data, 32'd0);
    chk("add_c2_z",    32'(bus.flag_z), 32'd1);
    chk("add_c2_c",    32'(bus.flag_c), 32'd1);
    @(negedge clk);
    chk("add_c3_hold_c", 32'(bus.flag_c), 32'd1);
    chk("add_c3_wbv",    32'(bus.wb_valid), 32'd0);
    @(posedge clk); #1;

    // SRA 0x80000000 by 4
    send(4'd8, 32'h8000_0000, 32'd4, 5'd7);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("sra_en", 32'(bus.alu_en), 32'd1);
      chk("sra_b",  bus.alu_b, 32'd1);
    end
    @(negedge clk);
    chk("sra_wbv",  32'(bus.wb_valid), 32'd1);
    chk("sra_data", bus.wb_data, 32'hF800_0000);
    chk("sra_z",    32'(bus.flag_z), 32'd0);
    @(posedge clk); #1;

    // SLA by 0
    send(4'd7, 32'h1234_5678, 32'd0, 5'd1);
    @(negedge clk);
    chk("sla0_b",  bus.alu_b, 32'd0);
    chk("sla0_en", 32'(bus.alu_en), 32'd1);
    @(negedge clk);
    chk("sla0_wbv",  32'(bus.wb_valid), 32'd1);
    chk("sla0_data", bus.wb_data, 32'h1234_5678);
    @(posedge clk); #1;

    // SRL with B=0x25: only the low 5 bits count -> shift by 5
    send(4'd9, 32'hFFFF_FFFF, 32'h25, 5'd2);
    repeat (5) @(negedge clk);
    @(negedge clk);
    chk("srl25_wbv",  32'(bus.wb_valid), 32'd1);
    chk("srl25_data", bus.wb_data, 32'h07FF_FFFF);
    @(posedge clk); #1;

    // SUB 5-5 with a second request held valid behind it
    bus.req_op = 4'd2; bus.req_a = 32'd5; bus.req_b = 32'd5; bus.req_dst = 5'd9;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_op = 4'd3; bus.req_a = 32'h0F0F; bus.req_b = 32'hF0F0; bus.req_dst = 5'd10;
    @(negedge clk);
    chk("sub_c1_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    chk("sub_c2_ready", 32'(bus.req_ready), 32'(FWD));
    chk("sub_c2_wbv",   32'(bus.wb_valid), 32'd1);
    chk("sub_c2_data",  bus.wb_data, 32'd0);
    chk("sub_c2_z",     32'(bus.flag_z), 32'd1);
    chk("sub_c2_c",     32'(bus.flag_c), 32'd0);
    @(negedge clk);
    chk("sub_c3_ready", 32'(bus.req_ready), 32'(!FWD));
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Reset in the middle of a long SRL
    send(4'd9, 32'hFFFF_0000, 32'd10, 5'd4);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_alu_en", 32'(bus.alu_en), 32'd0);
    chk("arst_busy",   32'(bus.busy), 32'd0);
    chk("arst_wbv",    32'(bus.wb_valid), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("arst_ready_after", 32'(bus.req_ready), 32'd1);
    chk("arst_flag_z",      32'(bus.flag_z), 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("arst_no_wb", 32'(bus.wb_valid), 32'd0);
    end
    @(posedge clk); #1;

`ifdef ALU_SEQ_FWD_EN
    // XOR then NOT back-to-back through the write-back forward path
    bus.req_op = 4'd5; bus.req_a = 32'hF0; bus.req_b = 32'hFF; bus.req_dst = 5'd2;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_op = 4'd6; bus.req_a = 32'd0; bus.req_b = 32'd0; bus.req_dst = 5'd3;
    @(negedge clk);
    @(negedge clk);
    chk("fwd_c2_wbv",  32'(bus.wb_valid), 32'd1);
    chk("fwd_c2_data", bus.wb_data, 32'h0F);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("fwd_c3_wbv", 32'(bus.wb_valid), 32'd0);
    chk("fwd_c3_en",  32'(bus.alu_en), 32'd1);
    @(negedge clk);
    chk("fwd_c4_wbv",  32'(bus.wb_valid), 32'd1);
    chk("fwd_c4_data", bus.wb_data, 32'hFFFF_FFFF);
    repeat (3) @(posedge clk);
    #1;
`endif

    // Randomised traffic; request fields are scrambled after each accept
    for (int it = 0; it < 250; it++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send(op, a, b, 5'($urandom_range(0, 31)));
      bus.req_op = 4'($urandom);
      bus.req_a  = $urandom;
      bus.req_b  = $urandom;
      bus.req_dst = 5'($urandom);
    end

    repeat (40) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
